lcd_frame_capture: RTL and testbench

- Sits directly downstream of the PPU and consumes its pixel stream (2-bit shade per pixel, 160x144 per frame).
- Writes each frame into one bank of a ping-pong framebuffer. On a complete frame it flips banks so a host/display reader always sees the last complete frame.
- Emits per-frame status: done pulse, frame counter and error flags for bench checking and display backends.

---
 rtl/lcd_frame_capture_if.sv | 25 ++
 rtl/lcd_frame_capture.sv | 86 ++++++++
 tb/tb_lcd_frame_capture.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lcd_frame_capture_if.sv
// lcd_frame_capture_if: pixel stream, host read port and frame status of the LCD capture block
interface lcd_frame_capture_if #(
   parameter int PIX_BITS  = 2,
   parameter int ADDR_BITS = 15
);
   logic                 lcd_enable;
   logic                 frame_start;
   logic                 pix_valid;
   logic [PIX_BITS-1:0]  pix_data;
   logic [ADDR_BITS-1:0] rd_addr;
   logic [PIX_BITS-1:0]  rd_data;
   logic                 display_bank;
   logic                 frame_done;
   logic [15:0]          frame_count;
   logic                 short_frame_err;
   logic                 overrun_err;
   modport master (
      output lcd_enable, frame_start, pix_valid, pix_data, rd_addr,
      input  rd_data, display_bank, frame_done, frame_count, short_frame_err, overrun_err
   );
   modport slave (
      input  lcd_enable, frame_start, pix_valid, pix_data, rd_addr,
      output rd_data, display_bank, frame_done, frame_count, short_frame_err, overrun_err
   );
endinterface

// File: rtl/lcd_frame_capture.sv
// lcd_frame_capture: captures PPU frames into a ping-pong framebuffer, presenting the last complete frame
module lcd_frame_capture #(
   parameter int LCD_W     = 160,
   parameter int LCD_H     = 144,
   parameter int PIX_BITS  = 2,
   parameter int ADDR_BITS = 15
) (
   input logic clk,
   input logic reset,
   lcd_frame_capture_if.slave bus
);
   localparam int NPIX = LCD_W * LCD_H;
   localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(NPIX - 1);
   typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, HOLD} state_t;
   state_t               r_state, w_state_nx;
   logic [ADDR_BITS-1:0] r_ptr, w_ptr_nx, w_waddr;
   logic                 w_we, w_commit, w_short, w_over, w_rd_oob;
   logic                 r_disp, r_done, r_short, r_over;
   logic [15:0]          r_count;
   logic [PIX_BITS-1:0]  r_rd_data;
   logic [PIX_BITS-1:0]  r_mem0 [NPIX];
   logic [PIX_BITS-1:0]  r_mem1 [NPIX];
   always_comb begin
      w_state_nx = r_state;
      w_ptr_nx   = r_ptr;
      w_we       = 1'b0;
      w_commit   = 1'b0;
      w_short    = 1'b0;
      w_over     = 1'b0;
      w_waddr    = bus.frame_start ? '0 : r_ptr;
      w_rd_oob   = int'(bus.rd_addr) >= NPIX;
      if (!bus.lcd_enable) begin
         w_state_nx = IDLE;
         w_ptr_nx   = '0;
      end else if (r_state == IDLE) begin
         w_state_nx = WAIT_SOF;
      end else if (bus.frame_start) begin
         // start of frame outranks pointer increment; a coincident pixel lands at address 0
         w_state_nx = CAPTURE;
         w_we       = bus.pix_valid;
         w_ptr_nx   = ADDR_BITS'(bus.pix_valid);
         w_short    = (r_state == CAPTURE) && (r_ptr != '0);
      end else if (r_state == CAPTURE && bus.pix_valid) begin
         w_we       = 1'b1;
         w_commit   = r_ptr == LAST;
         w_ptr_nx   = w_commit ? '0 : r_ptr + ADDR_BITS'(1);
         w_state_nx = w_commit ? HOLD : CAPTURE;
      end else begin
         w_over = (r_state == HOLD) && bus.pix_valid;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_disp    <= 1'b0;
         r_done    <= 1'b0;
         r_count   <= '0;
         r_short   <= 1'b0;
         r_over    <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_ptr     <= w_ptr_nx;
         r_done    <= w_commit;
         r_disp    <= r_disp ^ w_commit;
         r_count   <= r_count + 16'(w_commit);
         r_short   <= r_short | w_short;
         r_over    <= r_over | w_over;
         r_rd_data <= w_rd_oob ? '0 : (r_disp ? r_mem1[bus.rd_addr] : r_mem0[bus.rd_addr]);
      end
   end
   // write bank is always the one not on display
   always_ff @(posedge clk) begin
      if (w_we && !reset) begin
         if (r_disp) r_mem0[w_waddr] <= bus.pix_data;
         else r_mem1[w_waddr] <= bus.pix_data;
      end
   end
   assign bus.rd_data         = r_rd_data;
   assign bus.display_bank    = r_disp;
   assign bus.frame_done      = r_done;
   assign bus.frame_count     = r_count;
   assign bus.short_frame_err = r_short;
   assign bus.overrun_err     = r_over;
endmodule

// File: tb/tb_lcd_frame_capture.sv
// tb_lcd_frame_capture: frame-done scoreboard plus read-vector table on a reduced-size frame
module tb_lcd_frame_capture;
   localparam int W  = 16;
   localparam int H  = 9;
   localparam int N  = W * H;
   localparam int AB = 8;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   lcd_frame_capture_if #(.PIX_BITS(2), .ADDR_BITS(AB)) bus ();
   lcd_frame_capture #(.LCD_W(W), .LCD_H(H), .PIX_BITS(2), .ADDR_BITS(AB)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   typedef struct {int cyc; logic [15:0] cnt; logic bank;} done_t;
   typedef struct {logic [AB-1:0] addr; logic [1:0] exp;} rd_vec_t;
   done_t      q[$];
   rd_vec_t    vt[8];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic [15:0] m_cnt;
   logic        m_bank;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      done_t e;
      if (!reset && bus.frame_done) begin
         if (q.size() == 0) check("unexpected_frame_done", 32'(bus.frame_done), 0);
         else begin
            e = q.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("done_count", 32'(bus.frame_count), 32'(e.cnt));
            check("done_bank", 32'(bus.display_bank), 32'(e.bank));
         end
      end
   end
   task automatic step(input logic en, input logic fs, input logic pv, input logic [1:0] d);
      @(posedge clk);
      #1;
      bus.lcd_enable  = en;
      bus.frame_start = fs;
      bus.pix_valid   = pv;
      bus.pix_data    = d;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      bus.lcd_enable = 0; bus.frame_start = 0; bus.pix_valid = 0; bus.pix_data = 0; bus.rd_addr = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      q.delete();
      m_cnt = 0;
      m_bank = 0;
   endtask
   // mode 0..3: constant shade, 4: addr[1:0], 5: 3 at address 0 then zeros
   task automatic frame(input int n, input int mode, input logic full, input int pre_exp);
      done_t e;
      for (int k = 0; k < n; k++) begin
         logic [1:0] d;
         d = (mode == 4) ? 2'(k) : (mode == 5) ? ((k == 0) ? 2'd3 : 2'd0) : 2'(mode);
         step(1, k == 0, 1, d);
         if (full && k == N - 1) begin
            m_cnt++;
            m_bank = ~m_bank;
            e.cyc = cyc + 1; e.cnt = m_cnt; e.bank = m_bank;
            q.push_back(e);
         end
      end
      step(1, 0, 0, 0);
      if (pre_exp >= 0) begin
         @(negedge clk);
         check("swap_read", 32'(bus.rd_data), pre_exp);
      end
      repeat (2) @(posedge clk);
      check("done_pending", q.size(), 0);
   endtask
   task automatic rd(input logic [AB-1:0] a, input logic [1:0] e, input string name);
      @(posedge clk);
      #1 bus.rd_addr = a;
      @(posedge clk);
      @(negedge clk);
      check(name, 32'(bus.rd_data), 32'(e));
   endtask
   task automatic status(input string name, input logic bank, input logic [15:0] cnt,
                         input logic sh, input logic ov);
      @(negedge clk);
      check({name, "_bank"}, 32'(bus.display_bank), 32'(bank));
      check({name, "_count"}, 32'(bus.frame_count), 32'(cnt));
      check({name, "_short"}, 32'(bus.short_frame_err), 32'(sh));
      check({name, "_overrun"}, 32'(bus.overrun_err), 32'(ov));
   endtask
   initial begin
      vt[0] = '{AB'(0), 2'd0};
      vt[1] = '{AB'(1), 2'd1};
      vt[2] = '{AB'(2), 2'd2};
      vt[3] = '{AB'(3), 2'd3};
      vt[4] = '{AB'(W + 1), 2'd1};
      vt[5] = '{AB'(N - 1), 2'((N - 1) % 4)};
      vt[6] = '{AB'(N), 2'd0};
      vt[7] = '{AB'(255), 2'd0};
      do_reset();
      status("reset", 0, 0, 0, 0);
      check("reset_done", 32'(bus.frame_done), 0);
      check("reset_rd_data", 32'(bus.rd_data), 0);
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      frame(N, 4, 1, -1);
      status("t1", 1, 1, 0, 0);
      for (int i = 0; i < 8; i++) rd(vt[i].addr, vt[i].exp, "t1_read");
      do_reset();
      step(1, 0, 0, 0);
      frame(N, 1, 1, -1);
      status("t2a", 1, 1, 0, 0);
      rd(0, 1, "t2a_read0");
      rd(AB'(N - 1), 1, "t2a_readlast");
      rd(5, 1, "t2a_read5");
      frame(N, 2, 1, 1);
      status("t2b", 0, 2, 0, 0);
      rd(5, 2, "t2b_read5");
      rd(AB'(N - 1), 2, "t2b_readlast");
      do_reset();
      step(1, 0, 0, 0);
      frame(50, 0, 0, -1);
      status("t3a", 0, 0, 0, 0);
      frame(N, 3, 1, -1);
      status("t3b", 1, 1, 1, 0);
      for (int a = 0; a < N; a++) rd(AB'(a), 3, "t3_read");
      do_reset();
      step(1, 0, 0, 0);
      frame(N, 1, 1, -1);
      status("t4a", 1, 1, 0, 0);
      step(1, 0, 1, 0);
      step(1, 0, 1, 2);
      step(1, 0, 1, 3);
      step(1, 0, 0, 0);
      status("t4b", 1, 1, 0, 1);
      rd(0, 1, "t4_read0");
      rd(7, 1, "t4_read7");
      rd(AB'(N - 1), 1, "t4_readlast");
      do_reset();
      step(1, 0, 0, 0);
      frame(70, 1, 0, -1);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      step(1, 0, 1, 1);
      step(1, 0, 1, 1);
      frame(N, 2, 1, -1);
      status("t5", 1, 1, 0, 0);
      rd(0, 2, "t5_read0");
      rd(69, 2, "t5_read69");
      rd(AB'(N - 1), 2, "t5_readlast");
      do_reset();
      step(1, 0, 0, 0);
      frame(N, 5, 1, -1);
      status("t6", 1, 1, 0, 0);
      rd(0, 3, "t6_read0");
      rd(1, 0, "t6_read1");
      rd(AB'(N - 1), 0, "t6_readlast");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
